da_fir3_seq: RTL and testbench
==============================

// Module: da_fir3_seq
// PURPOSE
//  Bit-serial sequencer for the 3-tap distributed-arithmetic (DA) FIR table.
//  Coefficient order is c0=-2, c1=3, c2=1.
//  Accepts three signed samples, then walks them LSB-first over W cycles.
//  Drives the 3-bit table address and shift-accumulates the signed table word.
//  The last (sign) bit is weighted negatively. Returns y = -2*x0 + 3*x1 + x2.
//  Sits between the sample source and the combinational DA case table; owns all timing.
// PARAMETERS
//  W   8   input sample width (two's complement); also number of serial cycles
//  LW  4   DA table word width (signed, range -2..4)
//  OW  W+LW  output width (localparam, not overridable)
// PORTS
//  clk         in   1    rising-edge clock
//  reset       in   1    synchronous, active-high
//  in_valid    in   1    x0/x1/x2 valid
//  in_ready    out  1    block can accept a sample set this cycle
//  x0,x1,x2    in   W    signed input samples (taps c0,c1,c2)
//  table_addr  out  3    DA table address: bit k = current bit of xk
//  table_data  in   LW   signed table word for table_addr (combinational, same cycle)
//  y           out  OW   signed filter result
//  out_valid   out  1    y valid; held until out_ready
//  out_ready   in   1    consumer accepts y
//  busy        out  1    high in RUN
// BEHAVIOUR
//  States: IDLE, RUN, DONE. Bit counter cnt has range 0..W-1.
//  Reset (any state, including mid-RUN):
//   - state=IDLE, cnt=0, acc=0, shift regs=0, y=0.
//   - out_valid=0, busy=0, table_addr=0. in_ready=1 on the first cycle after reset.
//  in_ready = (state==IDLE) | (state==DONE & out_ready). It is 0 in RUN, and in_valid is ignored there.
//  Accept edge (in_valid & in_ready):
//   - latch x0..x2 into shift regs, acc=0, cnt=0.
//   - state -> RUN.
//  RUN, each edge:
//   - table_addr = {s2[0],s1[0],s0[0]}; T = sign-extended table_data.
//   - cnt<W-1: acc += T<<cnt.
//   - cnt==W-1: y = acc - (T<<(W-1)), state -> DONE.
//   - shift regs >>1, cnt++.
//  All arithmetic is OW-bit signed; no overflow is possible for this coefficient set.
//  Latency: out_valid rises W edges after the accept edge (8 for W=8).
//  DONE:
//   - out_valid=1; y stable while out_ready=0.
//   - out_ready=1 & in_valid=1 at the same edge: result transfers and the next set is accepted (-> RUN).
//   - out_ready=1 & in_valid=0: -> IDLE, out_valid=0.
//   - y keeps its last value until overwritten.
//  Sustained throughput: one sample set per W+1 cycles.
//  busy=1 exactly in RUN. table_addr=0 outside RUN.
// TESTING
//  T1 Impulse: x0=1, x1=0, x2=0 -> y=-2 after 8 cycles; table_addr sequence 1,0,0,0,0,0,0,0.
//  T2 Sign/extremes:
//   - x=(1,1,1) -> y=2.
//   - x=(127,127,127) -> y=254.
//   - x=(-128,-128,-128) -> y=-256.
//   - x=(-128,127,-128) -> y=509.
//  T3 Backpressure:
//   - hold out_ready=0 for 5 cycles in DONE: y, out_valid stable, in_ready=0.
//   - then out_ready=1: transfer in one edge.
//  T4 Back-to-back: out_ready=1 and in_valid=1 continuously with 4 sample sets -> 4 correct results, each 9 cycles apart.
//  T5 Reset mid-RUN at cnt=3: next cycle IDLE, out_valid=0, y=0, in_ready=1; a following sample set computes correctly.
//  T6 Random: 1000 random sample sets with random out_ready -> every y matches -2*x0 + 3*x1 + x2; no loss or duplication.

Source files
------------

// File: rtl/da_fir3_seq.sv
// Bit-serial sequencer for a 3-tap distributed-arithmetic FIR (c0=-2, c1=3, c2=1).
// It latches one sample set and walks the three samples LSB-first over W cycles.
// Each cycle it presents the current bit triple as the table address and
// shift-accumulates the signed table word. The sign-bit cycle subtracts its term.
module da_fir3_seq #(
    parameter int W  = 8,
    parameter int LW = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        x0,
    input  logic [W-1:0]        x1,
    input  logic [W-1:0]        x2,
    output logic [2:0]          table_addr,
    input  logic [LW-1:0]       table_data,
    output logic [W+LW-1:0]     y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    localparam int OW = W + LW;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic [CW-1:0]          cnt_r;
    logic [W-1:0]           s0_r;
    logic [W-1:0]           s1_r;
    logic [W-1:0]           s2_r;
    logic signed [OW-1:0]   acc_r;
    logic signed [OW-1:0]   y_r;
    logic                   out_valid_r;
    logic                   busy_r;
    logic [2:0]             table_addr_r;

    logic                   accept_s;
    logic                   last_s;
    logic signed [OW-1:0]   t_ext_s;
    logic signed [OW-1:0]   t_shift_s;

    // A new set can enter when idle, or when the finished result leaves this same edge.
    assign in_ready  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
    assign accept_s  = in_valid & in_ready;
    assign last_s    = (cnt_r == CW'(W - 1));

    // Table word sign-extended to the full result width, weighted by the bit position.
    assign t_ext_s   = OW'($signed(table_data));
    assign t_shift_s = t_ext_s <<< cnt_r;

    assign y          = y_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign table_addr = table_addr_r;

    // Sequencer state, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CW{1'b0}};
            s0_r         <= {W{1'b0}};
            s1_r         <= {W{1'b0}};
            s2_r         <= {W{1'b0}};
            acc_r        <= {OW{1'b0}};
            y_r          <= {OW{1'b0}};
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            table_addr_r <= 3'd0;
        end else if (accept_s) begin
            // Accept from IDLE or from DONE (the latter also hands off the result).
            state_r      <= ST_RUN;
            cnt_r        <= {CW{1'b0}};
            s0_r         <= x0;
            s1_r         <= x1;
            s2_r         <= x2;
            acc_r        <= {OW{1'b0}};
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b1;
            // Address is registered one step ahead so it matches the shift regs.
            table_addr_r <= {x2[0], x1[0], x0[0]};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_RUN: begin
                    s0_r <= s0_r >> 1;
                    s1_r <= s1_r >> 1;
                    s2_r <= s2_r >> 1;
                    if (last_s) begin
                        // Sign-bit slice carries negative weight.
                        y_r          <= acc_r - t_shift_s;
                        cnt_r        <= {CW{1'b0}};
                        state_r      <= ST_DONE;
                        out_valid_r  <= 1'b1;
                        busy_r       <= 1'b0;
                        table_addr_r <= 3'd0;
                    end else begin
                        acc_r        <= acc_r + t_shift_s;
                        cnt_r        <= cnt_r + CW'(1);
                        table_addr_r <= {s2_r[1], s1_r[1], s0_r[1]};
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    out_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    table_addr_r <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_da_fir3_seq.sv
// Bench for da_fir3_seq: directed cases plus a randomized stream against an
// arithmetic reference (y = -2*x0 + 3*x1 + x2).
module tb_da_fir3_seq;

    localparam int W  = 8;
    localparam int LW = 4;
    localparam int OW = W + LW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x0, x1, x2;
    logic [2:0]    table_addr;
    logic [LW-1:0] table_data;
    logic [OW-1:0] y;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;

    da_fir3_seq #(.W(W), .LW(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x0         (x0),
        .x1         (x1),
        .x2         (x2),
        .table_addr (table_addr),
        .table_data (table_data),
        .y          (y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Combinational DA table: sum of the coefficients whose address bit is set.
    always_comb begin
        int tv;
        tv = 0;
        if (table_addr[0]) tv = tv - 2;
        if (table_addr[1]) tv = tv + 3;
        if (table_addr[2]) tv = tv + 1;
        table_data = LW'(tv);
    end

    function automatic int ref_y(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                 input logic signed [W-1:0] c);
        return -2 * int'(a) + 3 * int'(b) + int'(c);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check("wait_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Run one set through, checking busy/address every RUN cycle; ends in DONE.
    task automatic do_set(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        wait_ready();
        x0 = a; x1 = b; x2 = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            check("run_busy", {31'd0, busy}, 32'd1);
            check("run_addr", {29'd0, table_addr}, {29'd0, c[k], b[k], a[k]});
            check("run_out_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        check("done_out_valid", {31'd0, out_valid}, 32'd1);
        check("done_y", 32'($signed(y)), 32'(ref_y(a, b, c)));
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_addr", {29'd0, table_addr}, 32'd0);
        check("done_in_ready", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("take_out_valid", {31'd0, out_valid}, 32'd0);
        check("take_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Streaming run with a scoreboard; rnd=0 gives back-to-back fixed sets.
    task automatic stream(input int nsets, input bit rnd);
        int            expq[$];
        int            accepted, done, cyc, last_xfer, exp_v;
        logic [W-1:0]  fx[4][3];
        fx[0] = '{8'd3, 8'd250, 8'd17};
        fx[1] = '{8'd128, 8'd1, 8'd99};
        fx[2] = '{8'd77, 8'd200, 8'd5};
        fx[3] = '{8'd10, 8'd20, 8'd30};
        accepted = 0; done = 0; cyc = 0; last_xfer = -1;
        while (done < nsets && cyc < 40000) begin
            if (accepted < nsets) begin
                in_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
                if (rnd) begin
                    x0 = W'($urandom); x1 = W'($urandom); x2 = W'($urandom);
                end else begin
                    x0 = fx[accepted % 4][0]; x1 = fx[accepted % 4][1]; x2 = fx[accepted % 4][2];
                end
            end else begin
                in_valid = 1'b0;
            end
            out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            #1;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (expq.size() == 0) begin
                    check("stream_dup", 32'($signed(y)), 32'hDEAD_BEEF);
                end else begin
                    exp_v = expq.pop_front();
                    check(rnd ? "rand_y" : "b2b_y", 32'($signed(y)), 32'(exp_v));
                end
                if (!rnd && last_xfer >= 0) check("b2b_gap", 32'(cyc - last_xfer), 32'd9);
                last_xfer = cyc;
                done++;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                expq.push_back(ref_y(x0, x1, x2));
                accepted++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check(rnd ? "rand_count" : "b2b_count", 32'(done), 32'(nsets));
        check(rnd ? "rand_leftover" : "b2b_leftover", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x0 = '0; x1 = '0; x2 = '0;
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr", {29'd0, table_addr}, 32'd0);
        check("rst_y", 32'($signed(y)), 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        tick();
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // T1 impulse (address sequence 1,0,0,... checked inside do_set)
        do_set(8'd1, 8'd0, 8'd0);
        take();

        // T2 sign and extremes
        do_set(8'd1, 8'd1, 8'd1);       take();
        do_set(8'd127, 8'd127, 8'd127); take();
        do_set(8'h80, 8'h80, 8'h80);    take();
        do_set(8'h80, 8'd127, 8'h80);   take();

        // T3 backpressure
        do_set(8'd200, 8'd33, 8'd91);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_y", 32'($signed(y)), 32'(ref_y(8'd200, 8'd33, 8'd91)));
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        out_ready = 1'b0;
        check("bp_released", {31'd0, out_valid}, 32'd0);

        // T4 back-to-back
        stream(4, 1'b0);

        // T5 reset mid-RUN at cnt=3
        wait_ready();
        x0 = 8'd5; x1 = 8'd6; x2 = 8'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("t5_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_y", 32'($signed(y)), 32'd0);
        check("t5_in_ready", {31'd0, in_ready}, 32'd1);
        check("t5_busy_low", {31'd0, busy}, 32'd0);
        check("t5_addr", {29'd0, table_addr}, 32'd0);
        do_set(8'd5, 8'd6, 8'd7);
        take();

        // T6 random stream with random backpressure
        stream(1000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
